// File: rtl/or1200_alarm_ctrl.sv
// Alarm sequencer for the privilege-checker results: arming window, glitch filter,
// sticky alarm with acknowledge/cooldown, and escalation to terminal lockdown.
module or1200_alarm_ctrl #(
    parameter int ARM_DLY  = 16,
    parameter int FILT_CYC = 2,
    parameter int ESC_CNT  = 4,
    parameter int COOL_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chk_en,
    input  logic       sr_ok,
    input  logic       pipeline_ok,
    input  logic       mmus_ok,
    input  logic       immu_fault_ok,
    input  logic       dmmu_fault_ok,
    input  logic       supv_consistent,
    input  logic       alarm_ack,
    output logic       alarm,
    output logic       alarm_irq,
    output logic       cpu_halt,
    output logic       lockdown,
    output logic [5:0] alarm_cause,
    output logic [3:0] esc_count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        MON   = 3'd1,
        FILT  = 3'd2,
        ALARM = 3'd3,
        COOL  = 3'd4,
        LOCK  = 3'd5
    } state_t;

    localparam logic [7:0] ARM_LAST  = 8'(ARM_DLY - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOL_CYC - 1);
    localparam logic [3:0] FILT_N    = 4'(FILT_CYC);
    localparam logic [3:0] ESC_N     = 4'(ESC_CNT);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] filt_q, filt_d;
    logic [5:0] cause_q, cause_d;
    logic [3:0] esc_q, esc_d;
    logic       alarm_q, irq_q, halt_q, lock_q;
    logic [5:0] f;

    assign f = ~{sr_ok, pipeline_ok, mmus_ok, immu_fault_ok, dmmu_fault_ok, supv_consistent};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        filt_d  = filt_q;
        cause_d = cause_q;
        esc_d   = esc_q;
        case (state_q)
            ARM: begin
                timer_d = timer_q + 8'd1;
                if (timer_q == ARM_LAST) begin
                    state_d = MON;
                    timer_d = 8'd0;
                end
            end
            MON: begin
                if (chk_en && (f != 6'd0)) begin
                    filt_d  = 4'd1;
                    cause_d = f;
                    state_d = (FILT_N == 4'd1) ? ALARM : FILT;
                end
            end
            FILT: begin
                // Any clean or disabled cycle breaks the run, whatever bits faulted.
                if (chk_en && (f != 6'd0)) begin
                    filt_d  = filt_q + 4'd1;
                    cause_d = cause_q | f;
                    if (filt_q + 4'd1 == FILT_N) state_d = ALARM;
                end else begin
                    state_d = MON;
                    filt_d  = 4'd0;
                    cause_d = 6'd0;
                end
            end
            ALARM: begin
                // Acknowledge takes priority over a fault arriving in the same cycle.
                if (alarm_ack) begin
                    esc_d = esc_q + 4'd1;
                    if (esc_q + 4'd1 == ESC_N) begin
                        state_d = LOCK;
                    end else begin
                        state_d = COOL;
                        timer_d = 8'd0;
                        cause_d = 6'd0;
                        filt_d  = 4'd0;
                    end
                end else begin
                    cause_d = cause_q | f;
                end
            end
            COOL: begin
                timer_d = timer_q + 8'd1;
                if (timer_q == COOL_LAST) begin
                    state_d = MON;
                    timer_d = 8'd0;
                end
            end
            LOCK: ;
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARM;
            timer_q <= 8'd0;
            filt_q  <= 4'd0;
            cause_q <= 6'd0;
            esc_q   <= 4'd0;
            alarm_q <= 1'b0;
            irq_q   <= 1'b0;
            halt_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            filt_q  <= filt_d;
            cause_q <= cause_d;
            esc_q   <= esc_d;
            alarm_q <= (state_d == ALARM) || (state_d == LOCK);
            irq_q   <= (state_d == ALARM);
            halt_q  <= (state_d == ALARM) || (state_d == LOCK);
            lock_q  <= (state_d == LOCK);
        end
    end

    assign alarm       = alarm_q;
    assign alarm_irq   = irq_q;
    assign cpu_halt    = halt_q;
    assign lockdown    = lock_q;
    assign alarm_cause = cause_q;
    assign esc_count   = esc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_or1200_alarm_ctrl.sv
// Bench for or1200_alarm_ctrl: directed plan steps followed by random traffic,
// every cycle compared against a counter-based reference model.
module tb_or1200_alarm_ctrl;

    localparam int ARM_DLY  = 16;
    localparam int FILT_CYC = 2;
    localparam int ESC_CNT  = 4;
    localparam int COOL_CYC = 8;

    logic       clk = 1'b0;
    logic       rst, chk_en, alarm_ack;
    logic [5:0] okv;  // {sr, pipeline, mmus, immu_fault, dmmu_fault, supv}
    logic       alarm, alarm_irq, cpu_halt, lockdown;
    logic [5:0] alarm_cause;
    logic [3:0] esc_count;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: phases tracked as countdowns and flags.
    int         m_arm_left, m_cool_left, m_run, m_esc;
    logic       m_alarm, m_lock;
    logic [5:0] m_cause;

    or1200_alarm_ctrl #(
        .ARM_DLY(ARM_DLY), .FILT_CYC(FILT_CYC), .ESC_CNT(ESC_CNT), .COOL_CYC(COOL_CYC)
    ) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en),
        .sr_ok(okv[5]), .pipeline_ok(okv[4]), .mmus_ok(okv[3]),
        .immu_fault_ok(okv[2]), .dmmu_fault_ok(okv[1]), .supv_consistent(okv[0]),
        .alarm_ack(alarm_ack),
        .alarm(alarm), .alarm_irq(alarm_irq), .cpu_halt(cpu_halt), .lockdown(lockdown),
        .alarm_cause(alarm_cause), .esc_count(esc_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic en, input logic [5:0] f, input logic a);
        if (r) begin
            m_arm_left = ARM_DLY; m_cool_left = 0; m_run = 0; m_esc = 0;
            m_alarm = 1'b0; m_lock = 1'b0; m_cause = 6'd0;
        end else if (m_lock) begin
        end else if (m_alarm) begin
            if (a) begin
                m_esc++;
                if (m_esc == ESC_CNT) m_lock = 1'b1;
                else begin
                    m_alarm = 1'b0; m_cool_left = COOL_CYC; m_cause = 6'd0;
                end
            end else m_cause = m_cause | f;
        end else if (m_arm_left > 0) begin
            m_arm_left--;
        end else if (m_cool_left > 0) begin
            m_cool_left--;
        end else if (en && f != 6'd0) begin
            m_run++;
            m_cause = m_cause | f;
            if (m_run == FILT_CYC) begin
                m_alarm = 1'b1; m_run = 0;
            end
        end else begin
            m_run = 0; m_cause = 6'd0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("alarm", {7'd0, alarm}, {7'd0, m_alarm | m_lock});
        chk("alarm_irq", {7'd0, alarm_irq}, {7'd0, m_alarm & ~m_lock});
        chk("cpu_halt", {7'd0, cpu_halt}, {7'd0, m_alarm | m_lock});
        chk("lockdown", {7'd0, lockdown}, {7'd0, m_lock});
        chk("alarm_cause", {2'd0, alarm_cause}, {2'd0, m_cause});
        chk("esc_count", {4'd0, esc_count}, 8'(m_esc));
    endtask

    // Drive one cycle, advance the model at the edge, compare just after it.
    task automatic step(input logic r, input logic en, input logic [5:0] ok, input logic a);
        rst = r; chk_en = en; okv = ok; alarm_ack = a;
        @(posedge clk);
        model_step(r, en, ~ok, a);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 6'h3f, 1'b0);
    endtask

    initial begin
        logic [5:0] ok_r;
        logic       rr, ee, aa;

        // Arming window: pipeline fault ignored for 16 cycles, alarm at cycle 18.
        step(1'b1, 1'b1, 6'h3f, 1'b0);
        chk("reset_state", {5'd0, dbg_state}, 8'd0);
        for (int i = 0; i < ARM_DLY; i++) step(1'b0, 1'b1, 6'b101111, 1'b0);
        chk("arm_quiet", {7'd0, alarm}, 8'd0);
        step(1'b0, 1'b1, 6'b101111, 1'b0);
        step(1'b0, 1'b1, 6'b101111, 1'b0);
        chk("arm_alarm", {7'd0, alarm}, 8'd1);
        chk("arm_cause", {2'd0, alarm_cause}, 8'b010000);

        // Ack, then a supervisor fault through cooldown and into monitoring.
        step(1'b0, 1'b1, 6'h3f, 1'b1);
        chk("ack_esc", {4'd0, esc_count}, 8'd1);
        for (int i = 0; i < COOL_CYC; i++) step(1'b0, 1'b1, 6'b111110, 1'b0);
        chk("cool_quiet", {7'd0, alarm}, 8'd0);
        step(1'b0, 1'b1, 6'b111110, 1'b0);
        step(1'b0, 1'b1, 6'b111110, 1'b0);
        chk("post_cool_alarm", {7'd0, alarm}, 8'd1);

        // Glitch filter, then differing bits on consecutive cycles.
        step(1'b0, 1'b1, 6'h3f, 1'b1);
        idle(COOL_CYC + 2);
        step(1'b0, 1'b1, 6'b011111, 1'b0);
        idle(3);
        chk("glitch_cause", {2'd0, alarm_cause}, 8'd0);
        step(1'b0, 1'b1, 6'b110111, 1'b0);
        step(1'b0, 1'b1, 6'b111101, 1'b0);
        chk("mixed_alarm", {7'd0, alarm}, 8'd1);
        chk("mixed_cause", {2'd0, alarm_cause}, 8'b001010);

        // chk_en low in ALARM still accumulates; ack beats a coincident fault.
        step(1'b0, 1'b0, 6'b011111, 1'b0);
        chk("alarm_en0_cause", {2'd0, alarm_cause}, 8'b101010);
        step(1'b0, 1'b1, 6'b111011, 1'b1);
        chk("ack_wins_cause", {2'd0, alarm_cause}, 8'd0);
        chk("ack_wins_esc", {4'd0, esc_count}, 8'd3);
        idle(COOL_CYC);

        // chk_en gating in MON and FILT.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("en0_mon", {7'd0, alarm}, 8'd0);
        step(1'b0, 1'b1, 6'b111101, 1'b0);
        step(1'b0, 1'b0, 6'b111101, 1'b0);
        chk("en0_filt_cause", {2'd0, alarm_cause}, 8'd0);
        step(1'b0, 1'b1, 6'b111101, 1'b0);
        step(1'b0, 1'b1, 6'b111101, 1'b0);

        // Fourth ack locks; later acks are ignored; reset clears lock.
        step(1'b0, 1'b1, 6'h3f, 1'b1);
        chk("lock", {7'd0, lockdown}, 8'd1);
        chk("lock_irq", {7'd0, alarm_irq}, 8'd0);
        step(1'b0, 1'b1, 6'h00, 1'b1);
        chk("lock_esc", {4'd0, esc_count}, 8'd4);
        step(1'b1, 1'b1, 6'h3f, 1'b0);
        chk("unlock_state", {5'd0, dbg_state}, 8'd0);

        // Reset in the middle of filtering.
        idle(ARM_DLY);
        step(1'b0, 1'b1, 6'b011111, 1'b0);
        step(1'b1, 1'b1, 6'b011111, 1'b0);
        chk("rst_filt_state", {5'd0, dbg_state}, 8'd0);
        chk("rst_filt_cause", {2'd0, alarm_cause}, 8'd0);

        // Random traffic against the model.
        ok_r = 6'h3f;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int b = 0; b < 6; b++) ok_r[b] = ($urandom_range(0, 9) != 0);
            end
            rr = ($urandom_range(0, 199) == 0);
            ee = ($urandom_range(0, 9) != 0);
            aa = ($urandom_range(0, 4) == 0);
            step(rr, ee, ok_r, aa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or1200_alarm_ctrl.md
Name: or1200_alarm_ctrl

Overview:
- Sequencing and response controller for the privilege-checker assertions.
- Consumes the six per-cycle "ok" results from the CPU-level and top-level checkers.
- Suppresses checks during a post-reset arming window and filters single-cycle glitches.
- Raises a sticky alarm with a cause vector, holds the CPU in halt until software acknowledges, and escalates to permanent lockdown after repeated alarms.

Parameters:
- ARM_DLY, 16: cycles after reset during which check results are ignored (1..255).
- FILT_CYC, 2: consecutive faulty cycles required to raise an alarm (1..15).
- ESC_CNT, 4: number of acknowledged alarms that triggers lockdown (1..15).
- COOL_CYC, 8: cycles after an acknowledge during which faults are ignored (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- chk_en  in  1  software check enable; 0 suppresses new detection.
- sr_ok  in  1  SR check passed.
- pipeline_ok  in  1  pipeline check passed.
- mmus_ok  in  1  MMU config check passed.
- immu_fault_ok  in  1  IMMU fault check passed.
- dmmu_fault_ok  in  1  DMMU fault check passed.
- supv_consistent  in  1  supervisor-mode consistency passed.
- alarm_ack  in  1  one-cycle acknowledge from the handler.
- alarm  out  1  alarm active.
- alarm_irq  out  1  interrupt request; level, held until acknowledged.
- cpu_halt  out  1  stall request to the CPU.
- lockdown  out  1  terminal lockdown indicator.
- alarm_cause  out  6  sticky fault vector.
- esc_count  out  4  number of acknowledged alarms.

Behaviour:
- Fault vector: f[5:0] = ~{sr_ok, pipeline_ok, mmus_ok, immu_fault_ok, dmmu_fault_ok, supv_consistent}. alarm_cause uses the same bit order.
- All outputs are registered or decoded from the state register. No combinational input-to-output path.
- Reset (rst=1 at an edge): state=ARM, timer=0, filt_cnt=0, esc_count=0, alarm_cause=0. All 1-bit outputs 0. Reset applies from any state, including LOCK.
- ARM:
  - Timer increments each cycle; f is ignored.
  - When timer==ARM_DLY-1, go to MON.
- MON:
  - If chk_en=1 and f!=0: set filt_cnt=1 and alarm_cause=f.
  - If FILT_CYC==1, go directly to ALARM; otherwise go to FILT.
- FILT:
  - If f!=0 and chk_en=1: filt_cnt++ and alarm_cause|=f. When filt_cnt+1==FILT_CYC, go to ALARM.
  - If f==0 or chk_en=0: go to MON, filt_cnt=0, alarm_cause=0.
  - Consecutive cycles are required even if the faulting bits differ between cycles.
- ALARM:
  - Outputs: alarm=1, alarm_irq=1, cpu_halt=1.
  - alarm_cause|=f every cycle, regardless of chk_en.
  - On alarm_ack=1, esc_count++. If the new count==ESC_CNT, go to LOCK; else go to COOL with timer=0 and alarm_cause=0.
  - If ack coincides with a new fault, ack wins and the fault is not recorded.
- COOL:
  - alarm=0; f is ignored.
  - Timer counts to COOL_CYC-1, then go to MON.
- LOCK:
  - Outputs: alarm=1, cpu_halt=1, lockdown=1, alarm_irq=0.
  - alarm_cause is frozen; alarm_ack is ignored. Exit only by rst.
- alarm_ack outside ALARM is ignored.
- chk_en=0 has no effect in ARM, ALARM, COOL or LOCK.
- Latency: with FILT_CYC consecutive fault cycles starting in MON at cycle t, alarm is high in cycle t+FILT_CYC.
- esc_count saturates at ESC_CNT; it never wraps because LOCK is terminal.

Test Plan:
- Arming window: rst for 1 cycle, then pipeline_ok=0 held for cycles 0..15 -> alarm stays 0. With pipeline_ok=0 still held at cycle 16 (in MON), alarm=1 at cycle 18 and alarm_cause=6'b010000.
- Glitch filter: in MON, sr_ok=0 for 1 cycle, then 1 -> alarm never asserts and alarm_cause returns to 0. Then mmus_ok=0 in cycle t and dmmu_fault_ok=0 in cycle t+1 -> alarm=1 at t+2, alarm_cause=6'b001010.
- Ack and cooldown: in ALARM, pulse alarm_ack -> next cycle alarm=0, irq=0, halt=0, esc_count=1, cause=0. Then supv_consistent=0 for 8 cycles (COOL) -> no alarm. Held 2 more cycles in MON -> alarm=1.
- Escalation: 4 alarm/ack sequences -> after the 4th ack, lockdown=1, cpu_halt=1, alarm=1, irq=0, esc_count=4. A further alarm_ack has no effect. rst -> all outputs 0 and state=ARM.
- chk_en gating: chk_en=0 in MON with all six ok signals=0 -> no alarm. chk_en dropped during FILT -> return to MON with cause=0. chk_en=0 in ALARM -> alarm held and cause still accumulates.
- Simultaneous events: alarm_ack in the same cycle as a new immu_fault_ok=0 -> transition to COOL, cause=0. rst asserted mid-FILT -> next cycle state=ARM with all outputs 0.
